// File: rtl/sync_fifo_thresh_pkg.sv
// Shared constants and helpers for the thresholded synchronous FIFO.
// Default widths live here so the top and storage agree on them.
package sync_fifo_thresh_pkg;

  localparam int DATA_W_DEF = 8;
  localparam int ADDR_W_DEF = 4;

  function automatic int depth_of(input int aw);
    return 1 << aw;
  endfunction

endpackage

// File: rtl/sync_fifo_mem.sv
// FIFO storage: one synchronous write port, one asynchronous read port.
// Contents are deliberately left unreset.
module sync_fifo_mem
  import sync_fifo_thresh_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [depth_of(ADDR_W)];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/sync_fifo_thresh.sv
// Synchronous FIFO with occupancy count, almost-full/empty thresholds,
// sticky overflow/underflow flags and selectable FWFT or registered read.
module sync_fifo_thresh
  import sync_fifo_thresh_pkg::*;
#(
  parameter int DATA_W    = DATA_W_DEF,
  parameter int ADDR_W    = ADDR_W_DEF,
  parameter int AFULL_TH  = depth_of(ADDR_W) - 2,
  parameter int AEMPTY_TH = 2,
  parameter int FWFT      = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  output logic [DATA_W-1:0] rd_data,
  input  logic              clr_err,
  output logic              full,
  output logic              empty,
  output logic              almost_full,
  output logic              almost_empty,
  output logic [ADDR_W:0]   count,
  output logic              overflow,
  output logic              underflow
);

  localparam int DEPTH = depth_of(ADDR_W);
  localparam int CW    = ADDR_W + 1;

  localparam logic [ADDR_W:0] DEPTH_C = CW'(DEPTH);
  localparam logic [ADDR_W:0] AF_C    = CW'(AFULL_TH);
  localparam logic [ADDR_W:0] AE_C    = CW'(AEMPTY_TH);

  if (!(AEMPTY_TH >= 0 && AEMPTY_TH < AFULL_TH && AFULL_TH <= DEPTH))
  begin : g_bad_thresh
    $error("sync_fifo_thresh: need 0 <= AEMPTY_TH < AFULL_TH <= DEPTH");
  end

  logic [ADDR_W:0]   wr_ptr;
  logic [ADDR_W:0]   rd_ptr;
  logic              wr_acc;
  logic              rd_acc;
  logic [DATA_W-1:0] head;

  assign full         = (count == DEPTH_C);
  assign empty        = (count == '0);
  assign almost_full  = (count >= AF_C);
  assign almost_empty = (count <= AE_C);

  // A full FIFO can still take a write when a read frees a slot.
  assign rd_acc = rd_en & ~empty;
  assign wr_acc = wr_en & (~full | rd_acc);

  sync_fifo_mem #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_mem (
    .clk   (clk),
    .we    (wr_acc),
    .waddr (wr_ptr[ADDR_W-1:0]),
    .wdata (wr_data),
    .raddr (rd_ptr[ADDR_W-1:0]),
    .rdata (head)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (wr_acc) wr_ptr <= wr_ptr + CW'(1);
      if (rd_acc) rd_ptr <= rd_ptr + CW'(1);
      unique case ({wr_acc, rd_acc})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
      // A new error in the same cycle wins over the clear.
      overflow  <= (wr_en & ~wr_acc) | (overflow & ~clr_err);
      underflow <= (rd_en & ~rd_acc) | (underflow & ~clr_err);
    end
  end

  if (FWFT != 0) begin : g_fwft
    assign rd_data = head;
  end else begin : g_reg_rd
    always_ff @(posedge clk) begin
      if (reset)       rd_data <= '0;
      else if (rd_acc) rd_data <= head;
    end
  end

endmodule

// File: tb/tb_sync_fifo_thresh.sv
// Directed bench: FWFT instance for fill/drain/threshold/flag cases,
// registered-read instance for latency and pointer wrap.
module tb_sync_fifo_thresh;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  logic       a_reset, a_wr_en, a_rd_en, a_clr_err;
  logic [7:0] a_wr_data, a_rd_data;
  logic       a_full, a_empty, a_afull, a_aempty, a_ovf, a_unf;
  logic [4:0] a_count;

  logic       b_reset, b_wr_en, b_rd_en, b_clr_err;
  logic [7:0] b_wr_data, b_rd_data;
  logic       b_full, b_empty, b_afull, b_aempty, b_ovf, b_unf;
  logic [4:0] b_count;

  sync_fifo_thresh u_a (
    .clk          (clk),
    .reset        (a_reset),
    .wr_en        (a_wr_en),
    .wr_data      (a_wr_data),
    .rd_en        (a_rd_en),
    .rd_data      (a_rd_data),
    .clr_err      (a_clr_err),
    .full         (a_full),
    .empty        (a_empty),
    .almost_full  (a_afull),
    .almost_empty (a_aempty),
    .count        (a_count),
    .overflow     (a_ovf),
    .underflow    (a_unf)
  );

  sync_fifo_thresh #(.FWFT(0)) u_b (
    .clk          (clk),
    .reset        (b_reset),
    .wr_en        (b_wr_en),
    .wr_data      (b_wr_data),
    .rd_en        (b_rd_en),
    .rd_data      (b_rd_data),
    .clr_err      (b_clr_err),
    .full         (b_full),
    .empty        (b_empty),
    .almost_full  (b_afull),
    .almost_empty (b_aempty),
    .count        (b_count),
    .overflow     (b_ovf),
    .underflow    (b_unf)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic a_idle();
    a_reset = 0; a_wr_en = 0; a_rd_en = 0; a_clr_err = 0;
  endtask

  logic [7:0] q[$];
  logic [7:0] hold_exp;
  logic       racc;
  logic       wacc;

  initial begin
    a_idle();
    a_wr_data = '0;
    b_reset = 1; b_wr_en = 0; b_rd_en = 0; b_clr_err = 0;
    b_wr_data = '0;
    a_reset = 1;
    step();
    step();
    a_idle();
    b_reset = 0;
    chk("rst_count", a_count, 0);
    chk("rst_empty", a_empty, 1);
    chk("rst_aempty", a_aempty, 1);
    chk("rst_full", a_full, 0);
    chk("rst_afull", a_afull, 0);
    chk("rst_ovf", a_ovf, 0);
    chk("rst_unf", a_unf, 0);
    chk("rst_b_rd_data", b_rd_data, 0);

    // fill 0x01..0x10
    for (int i = 1; i <= 16; i++) begin
      a_wr_en = 1; a_wr_data = 8'(i);
      step();
      if (i == 2)  chk("fill_aempty_c2", a_aempty, 1);
      if (i == 3)  chk("fill_aempty_c3", a_aempty, 0);
      if (i == 13) chk("fill_afull_c13", a_afull, 0);
      if (i == 14) chk("fill_afull_c14", a_afull, 1);
      if (i == 15) chk("fill_full_c15", a_full, 0);
    end
    a_idle();
    chk("fill_full", a_full, 1);
    chk("fill_count", a_count, 16);
    chk("fill_ovf0", a_ovf, 0);

    a_wr_en = 1; a_wr_data = 8'h11;
    step();
    a_idle();
    chk("ovf_set", a_ovf, 1);
    chk("ovf_count", a_count, 16);
    step();
    chk("ovf_sticky", a_ovf, 1);
    a_clr_err = 1;
    step();
    a_idle();
    chk("ovf_clr", a_ovf, 0);

    // drain in order
    for (int i = 1; i <= 16; i++) begin
      chk("drain_data", a_rd_data, 32'(i));
      a_rd_en = 1;
      step();
      if (16 - i == 3) chk("drain_aempty_c3", a_aempty, 0);
      if (16 - i == 2) chk("drain_aempty_c2", a_aempty, 1);
    end
    a_idle();
    chk("drain_empty", a_empty, 1);
    chk("drain_unf0", a_unf, 0);
    a_rd_en = 1;
    step();
    a_idle();
    chk("unf_set", a_unf, 1);
    chk("unf_count", a_count, 0);

    // clear with a simultaneous new underflow keeps the flag
    a_rd_en = 1; a_clr_err = 1;
    step();
    a_idle();
    chk("unf_clr_prio", a_unf, 1);
    a_clr_err = 1;
    step();
    a_idle();
    chk("unf_clr", a_unf, 0);

    // refill, then read+write while full
    for (int i = 0; i < 16; i++) begin
      a_wr_en = 1; a_wr_data = 8'(8'h20 + i);
      step();
    end
    a_idle();
    chk("refill_full", a_full, 1);
    a_wr_en = 1; a_rd_en = 1; a_wr_data = 8'hAA;
    step();
    a_idle();
    chk("rw_full_count", a_count, 16);
    chk("rw_full_ovf", a_ovf, 0);
    for (int i = 1; i <= 16; i++) begin
      chk("rw_drain", a_rd_data, (i == 16) ? 32'hAA : 32'(8'h20 + i));
      a_rd_en = 1;
      step();
    end
    a_idle();
    chk("rw_empty", a_empty, 1);

    // write with a read while empty: read rejected, word stored
    a_wr_en = 1; a_rd_en = 1; a_wr_data = 8'h5C;
    step();
    a_idle();
    chk("we_re_count", a_count, 1);
    chk("we_re_unf", a_unf, 1);
    chk("we_re_data", a_rd_data, 8'h5C);
    a_clr_err = 1; a_rd_en = 1;
    step();
    a_idle();
    chk("we_re_drain", a_count, 0);

    // reset mid-fill, with a write in the reset cycle
    for (int i = 0; i < 7; i++) begin
      a_wr_en = 1; a_wr_data = 8'(i);
      step();
    end
    a_idle();
    chk("mid_count7", a_count, 7);
    a_reset = 1; a_wr_en = 1; a_wr_data = 8'hEE;
    step();
    a_idle();
    chk("mid_rst_count", a_count, 0);
    chk("mid_rst_empty", a_empty, 1);
    step();
    chk("mid_rst_hold", a_count, 0);

    // registered-read instance: interleaved traffic across wrap
    hold_exp = '0;
    for (int i = 0; i < 64; i++) begin
      b_wr_en   = (i < 40);
      b_wr_data = 8'(i * 7 + 3);
      b_rd_en   = (i % 3 != 0) || (i >= 40);
      racc = b_rd_en && (q.size() > 0);
      wacc = b_wr_en && ((q.size() < 16) || racc);
      if (racc) hold_exp = q.pop_front();
      if (wacc) q.push_back(b_wr_data);
      step();
      chk("b_rd_data", b_rd_data, hold_exp);
      chk("b_count", b_count, q.size());
    end
    b_wr_en = 0; b_rd_en = 0;
    chk("b_empty", b_empty, 1);
    chk("b_ovf", b_ovf, 0);
    step();
    chk("b_rd_hold", b_rd_data, hold_exp);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
